sequence_game_controller: RTL



---
 rtl/sequence_game_controller_if.sv | 32 +++
 rtl/sequence_game_controller.sv | 128 ++++++++++++
 2 files changed

// File: rtl/sequence_game_controller_if.sv
// Control/status bundle between the memory-game controller and its datapath.
// master = controller side, slave = datapath side.
interface sequence_game_controller_if;
    logic       iniciar;
    logic       jogada;
    logic       chavesIgualMemoria;
    logic       enderecoIgualLimite;
    logic       fimL;
    logic       zeraC;
    logic       contaC;
    logic       zeraL;
    logic       contaL;
    logic       zeraR;
    logic       registraR;
    logic       pronto;
    logic       acertou;
    logic       errou;
    logic       timeout;
    logic [3:0] db_estado;

    modport master (
        input  iniciar, jogada, chavesIgualMemoria, enderecoIgualLimite, fimL,
        output zeraC, contaC, zeraL, contaL, zeraR, registraR,
        output pronto, acertou, errou, timeout, db_estado
    );

    modport slave (
        output iniciar, jogada, chavesIgualMemoria, enderecoIgualLimite, fimL,
        input  zeraC, contaC, zeraL, contaL, zeraR, registraR,
        input  pronto, acertou, errou, timeout, db_estado
    );
endinterface

// File: rtl/sequence_game_controller.sv
// Moore controller for the round-based memory game: sequences rounds, checks keys, times out idle players.
// Outputs decode from state only; one-cycle state steps, inactivity timeout counted only while waiting for a key.
module sequence_game_controller #(
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic                         clock,
    input  logic                         reset,
    sequence_game_controller_if.master   bus
);
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        INICIAL       = 4'h0,
        PREPARA       = 4'h1,
        INICIO_RODADA = 4'h2,
        ESPERA        = 4'h3,
        REGISTRA      = 4'h4,
        COMPARA       = 4'h5,
        PROX_JOGADA   = 4'h6,
        PROX_RODADA   = 4'h7,
        FIM_ACERTO    = 4'hA,
        FIM_TIMEOUT   = 4'hD,
        FIM_ERRO      = 4'hE
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            jogada_q;
    logic            play_edge;

    assign play_edge = bus.jogada & ~jogada_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= INICIAL;
            cnt_q    <= '0;
            jogada_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            jogada_q <= bus.jogada;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            INICIAL:       if (bus.iniciar) state_d = PREPARA;
            PREPARA:       state_d = INICIO_RODADA;
            INICIO_RODADA: state_d = ESPERA;
            // A key edge wins over a simultaneous timeout.
            ESPERA: begin
                if (play_edge)             state_d = REGISTRA;
                else if (cnt_q == CNT_LAST) state_d = FIM_TIMEOUT;
            end
            REGISTRA:      state_d = COMPARA;
            COMPARA: begin
                if (!bus.chavesIgualMemoria)                  state_d = FIM_ERRO;
                else if (bus.enderecoIgualLimite && bus.fimL) state_d = FIM_ACERTO;
                else if (bus.enderecoIgualLimite)             state_d = PROX_RODADA;
                else                                          state_d = PROX_JOGADA;
            end
            PROX_JOGADA:   state_d = ESPERA;
            PROX_RODADA:   state_d = INICIO_RODADA;
            FIM_ACERTO, FIM_TIMEOUT, FIM_ERRO:
                           if (bus.iniciar) state_d = PREPARA;
            default:       state_d = INICIAL;
        endcase
    end

    // Zero on every cycle outside ESPERA, so each fresh entry starts counting from 0.
    always_comb begin
        cnt_d = '0;
        if (state_q == ESPERA && state_d == ESPERA) cnt_d = cnt_q + CW'(1);
    end

    logic zera_c, conta_c, zera_l, conta_l, zera_r, registra_r;
    logic fim_ok, fim_err, fim_to;

    always_comb begin
        zera_c     = 1'b0;
        conta_c    = 1'b0;
        zera_l     = 1'b0;
        conta_l    = 1'b0;
        zera_r     = 1'b0;
        registra_r = 1'b0;
        fim_ok     = 1'b0;
        fim_err    = 1'b0;
        fim_to     = 1'b0;
        case (state_q)
            PREPARA: begin
                zera_c = 1'b1;
                zera_l = 1'b1;
                zera_r = 1'b1;
            end
            INICIO_RODADA: begin
                zera_c = 1'b1;
                zera_r = 1'b1;
            end
            REGISTRA:    registra_r = 1'b1;
            PROX_JOGADA: conta_c    = 1'b1;
            PROX_RODADA: conta_l    = 1'b1;
            FIM_ACERTO:  fim_ok     = 1'b1;
            FIM_ERRO:    fim_err    = 1'b1;
            FIM_TIMEOUT: fim_to     = 1'b1;
            default: ;
        endcase
    end

    assign bus.zeraC     = zera_c;
    assign bus.contaC    = conta_c;
    assign bus.zeraL     = zera_l;
    assign bus.contaL    = conta_l;
    assign bus.zeraR     = zera_r;
    assign bus.registraR = registra_r;
    assign bus.acertou   = fim_ok;
    assign bus.errou     = fim_err;
    assign bus.timeout   = fim_to;
    assign bus.pronto    = fim_ok | fim_err | fim_to;
    assign bus.db_estado = state_q;

    // Exactly one end-cause flag whenever the game reports finished.
    a_one_cause: assert property (@(posedge clock) disable iff (reset)
        bus.pronto |-> $onehot({bus.acertou, bus.errou, bus.timeout}));
    a_no_cause_idle: assert property (@(posedge clock) disable iff (reset)
        !bus.pronto |-> ({bus.acertou, bus.errou, bus.timeout} == 3'b000));
endmodule
